// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU run sequencer: the state encoding and the
// default widths used by the top, the bus interface and the bench.
package tpu_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/tpu_run_sequencer_if.sv
// Weight-stream and weight-memory write bus of the run sequencer.
//   in_valid/in_ready/in_data : host weight stream (valid/ready handshake)
//   mem_we/mem_ch/mem_addr/mem_wdata : write port toward the MM weight memories
// master = sequencer side, slave = host/memory side.
interface tpu_run_sequencer_if
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mem_we;
  logic [NUM_CH-1:0] mem_ch;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_ch, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_ch, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tpu_seq_addr_gen.sv
// Channel/address counter for channel-major weight loading.
//   clr    : return to ch0/addr0
//   adv    : step to the next word (addr wraps at WORDS-1, then ch steps)
//   ch     : current channel index
//   addr   : current word address
//   last_c : current position is the final word of the final channel
module tpu_seq_addr_gen #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WORDS  = 2,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [CH_W-1:0]   ch,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_wrap_c;

  assign last_c = (ch_q == CH_W'(NUM_CH - 1)) && addr_wrap_c;
  assign ch     = ch_q;
  assign addr   = addr_q;

  // Next position; clear has priority over advance.
  always_comb begin
    ch_d        = ch_q;
    addr_d      = addr_q;
    addr_wrap_c = (addr_q == ADDR_W'(WORDS - 1));
    if (clr) begin
      ch_d   = '0;
      addr_d = '0;
    end else if (adv) begin
      if (addr_wrap_c) begin
        addr_d = '0;
        ch_d   = last_c ? '0 : ch_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q   <= '0;
      addr_q <= '0;
    end else begin
      ch_q   <= ch_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/tpu_run_sequencer.sv
// TPU run sequencer: loads NUM_CH x WORDS weight words into the weight
// memories (channel-major), pulses start for START_CYC cycles, then waits
// for tpu_ready with a TIMEOUT bound and reports done/timed_out/run_cycles.
//   clk, rst (async, active-low)
//   go, skip_load     : run request (sampled in IDLE), weight reuse request
//   bus (master)      : weight stream in, memory write port out
//   start, tpu_ready  : TPU handshake
//   busy, done, timed_out, run_cycles : status
// Optional feature macro: TPU_SEQ_SKIP_LOAD_EN (go with skip_load bypasses LOAD).
module tpu_run_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned WORDS     = 2,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned TIMEOUT   = 20,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                skip_load,
  tpu_run_sequencer_if.master bus,
  output logic                start,
  input  logic                tpu_ready,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [CNT_W-1:0]    run_cycles
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic              timed_out_q, timed_out_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [NUM_CH-1:0] mem_ch_q, mem_ch_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_c;
  logic              ag_clr, ag_adv, ag_last;
  logic [CH_W-1:0]   ag_ch;
  logic [ADDR_W-1:0] ag_addr;

`ifndef TPU_SEQ_SKIP_LOAD_EN
  logic skip_load_unused;
  assign skip_load_unused = skip_load;
`endif

  tpu_seq_addr_gen #(
    .NUM_CH (NUM_CH),
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (ag_clr),
    .adv    (ag_adv),
    .ch     (ag_ch),
    .addr   (ag_addr),
    .last_c (ag_last)
  );

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    run_cycles_d = run_cycles_q;
    timed_out_d  = timed_out_q;
    mem_we_d     = 1'b0;
    mem_ch_d     = mem_ch_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ag_clr       = 1'b0;
    ag_adv       = 1'b0;
    accept_c     = bus.in_valid & in_ready_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          ag_clr       = 1'b1;
          sc_d         = '0;
          run_cycles_d = '0;
          timed_out_d  = 1'b0;
`ifdef TPU_SEQ_SKIP_LOAD_EN
          state_d = skip_load ? S_START : S_LOAD;
`else
          state_d = S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          mem_we_d    = 1'b1;
          mem_ch_d    = NUM_CH'(1) << ag_ch;
          mem_addr_d  = ag_addr;
          mem_wdata_d = bus.in_data;
          ag_adv      = 1'b1;
          if (ag_last) state_d = S_SETTLE;
        end
      end
      // The final write lands here, so start can never overlap a write.
      S_SETTLE: state_d = S_START;
      S_START: begin
        if (sc_q == SC_W'(START_CYC - 1)) state_d = S_WAIT;
        else                              sc_d    = sc_q + 1'b1;
      end
      // Ready is checked before the timeout so a ready on the last cycle wins.
      S_WAIT: begin
        run_cycles_d = run_cycles_q + 1'b1;
        if (tpu_ready) begin
          state_d     = S_DONE;
          timed_out_d = 1'b0;
        end else if (run_cycles_d == CNT_W'(TIMEOUT)) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs registered so they line up with the state register.
    in_ready_d = (state_d == S_LOAD);
    start_d    = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sc_q         <= '0;
      run_cycles_q <= '0;
      timed_out_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_ch_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      run_cycles_q <= run_cycles_d;
      timed_out_q  <= timed_out_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_ch_q     <= mem_ch_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_ch    = mem_ch_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign start         = start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timed_out     = timed_out_q;
  assign run_cycles    = run_cycles_q;
endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Bench for tpu_run_sequencer: table of run scenarios plus a reset-mid-run
// sequence; memory writes are checked against a queue of expected writes.
module tb_tpu_run_sequencer;
  import tpu_pkg::*;

  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned WORDS     = 2;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned START_CYC = 2;
  localparam int unsigned TIMEOUT   = 20;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NWORDS    = NUM_CH * WORDS;

  typedef struct {
    logic [NUM_CH-1:0] ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int          gap;            // idle cycles between words
    int          ready_cyc;      // WAIT cycle with tpu_ready=1 (0 = never)
    bit          ready_in_start; // hold tpu_ready high through START
    bit          noise;          // go/in_valid high during WAIT
    bit          skip;           // skip_load with go
    logic [63:0] base;
    logic [63:0] step;
    bit          exp_to;
    int          exp_rc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic             skip_load = 1'b0;
  logic             tpu_ready = 1'b0;
  logic             start, busy, done, timed_out;
  logic [CNT_W-1:0] run_cycles;

  int  n_vec = 0;
  int  n_bad = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  vec_t vecs[7];

  tpu_run_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  tpu_run_sequencer #(
    .NUM_CH(NUM_CH), .WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .START_CYC(START_CYC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .skip_load  (skip_load),
    .bus        (bus),
    .start      (start),
    .tpu_ready  (tpu_ready),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && bus.mem_we) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_ch",   64'(bus.mem_ch),   64'(mon_e.ch));
        check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check("wr_data", bus.mem_wdata,     mon_e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input int i, input logic [DATA_W-1:0] w);
    wr_t e;
    int  t;
    e.ch   = NUM_CH'(1) << (i / WORDS);
    e.addr = ADDR_W'(i % WORDS);
    e.data = w;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 64'(t < 50), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_run(input vec_t v);
    bit do_load;
    int cnt;
    int n;
    do_load = 1'b1;
`ifdef TPU_SEQ_SKIP_LOAD_EN
    if (v.skip) do_load = 1'b0;
`endif
    go = 1'b1;
    skip_load = v.skip;
    @(negedge clk);
    go = 1'b0;
    skip_load = 1'b0;
    check("busy_after_go", 64'(busy), 64'd1);
    check("to_cleared", 64'(timed_out), 64'd0);
    if (do_load) begin
      for (int i = 0; i < int'(NWORDS); i++) begin
        if (i > 0) repeat (v.gap) @(negedge clk);
        send_word(i, v.base + v.step * DATA_W'(i));
      end
      check("settle_no_start", 64'(start), 64'd0);
      check("settle_last_we", 64'(bus.mem_we), 64'd1);
      @(negedge clk);
    end
    check("start_rise", 64'(start), 64'd1);
    cnt = 0;
    while (start && cnt < 10) begin
      check("start_no_we", 64'(bus.mem_we), 64'd0);
      tpu_ready = v.ready_in_start;
      cnt++;
      @(negedge clk);
    end
    tpu_ready = 1'b0;
    check("start_len", 64'(cnt), 64'(START_CYC));
    n = 1;
    while (n <= 40) begin
      tpu_ready    = (n == v.ready_cyc);
      go           = v.noise;
      bus.in_valid = v.noise;
      @(negedge clk);
      tpu_ready    = 1'b0;
      go           = 1'b0;
      bus.in_valid = 1'b0;
      if (done) break;
      n++;
    end
    check("wait_len", 64'(n), 64'(v.exp_rc));
    check("done_pulse", 64'(done), 64'd1);
    check("timed_out", 64'(timed_out), 64'(v.exp_to));
    check("run_cycles", 64'(run_cycles), 64'(v.exp_rc));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("to_hold", 64'(timed_out), 64'(v.exp_to));
    check("rc_hold", 64'(run_cycles), 64'(v.exp_rc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         gap rdy  rdyS noise skip base                    step           to rc
    vecs[0] = '{0,  5,  0,   0,    0,   64'd1,                  64'd0,         0, 5};
    vecs[1] = '{3,  5,  0,   0,    0,   64'hA5A5_0000_0000_0010, 64'd1,        0, 5};
    vecs[2] = '{0,  0,  0,   1,    0,   64'hDEAD_BEEF_0000_0000, 64'h100,      1, 20};
    vecs[3] = '{1,  20, 0,   0,    0,   64'h0F0F_1234_5678_9ABC, 64'h1111,     0, 20};
    vecs[4] = '{2,  1,  1,   0,    0,   64'h0123_4567_89AB_CDEF, 64'h2_0000,   0, 1};
    vecs[5] = '{0,  21, 0,   0,    0,   64'h8000_0000_0000_0000, 64'h7,        1, 20};
    vecs[6] = '{0,  19, 0,   0,    1,   64'h5555_AAAA_5555_AAAA, 64'h3,        0, 19};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_start", 64'(start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_to", 64'(timed_out), 64'd0);
    check("rst_rc", 64'(run_cycles), 64'd0);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_ch", 64'(bus.mem_ch), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      do_run(vecs[k]);
      repeat (2) @(negedge clk);
    end

    // Reset during START, then a full rerun must load from ch0/addr0.
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < int'(NWORDS); i++) send_word(i, 64'hC0DE_0000 + DATA_W'(i));
    @(negedge clk);
    check("rst_run_start", 64'(start), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_start", 64'(start), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_we", 64'(bus.mem_we), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_run(vecs[1]);
    repeat (2) @(negedge clk);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tpu_run_sequencer.md
Name: tpu_run_sequencer

Overview:
- Hardware replacement for the bench-side bring-up of the TPU.
- Accepts a stream of weight words and writes them into NUM_CH per-layer weight memories, channel-major.
- Then pulses start to the TPU for START_CYC cycles and waits for ready, bounded by a timeout.
- Reports done, timeout and run length. Sits between the host/config stream and the TPU top.

Parameters:
- NUM_CH, 2, number of weight memories (MM instances) to load
- WORDS, 2, words per memory
- DATA_W, 64, weight word width
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W >= WORDS
- START_CYC, 2, cycles start is held high
- TIMEOUT, 20, max WAIT cycles before abort
- CNT_W, 8, width of run-cycle counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  run request, sampled in IDLE only
- skip_load  in  1  reuse loaded weights (only with optional feature)
- in_valid  in  1  weight stream valid
- in_ready  out  1  weight stream ready
- in_data  in  DATA_W  weight word
- mem_we  out  1  memory write strobe
- mem_ch  out  NUM_CH  one-hot target memory select
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  write data
- start  out  1  TPU start
- tpu_ready  in  1  TPU completion
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run
- timed_out  out  1  status of last run
- run_cycles  out  CNT_W  WAIT cycles of last run

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including start, mem_we, in_ready and the counters. Reset mid-run drops start and mem_we immediately; no partial-state retention.
- States: IDLE, LOAD, SETTLE, START, WAIT, DONE.
- IDLE: go=1 -> LOAD. Clears timed_out, run_cycles and the channel/address counters.
- LOAD:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On an accept in cycle k, cycle k+1 has mem_we=1, mem_wdata=word, mem_ch=onehot(ch), mem_addr=addr (registered, latency 1).
  - addr increments; at WORDS-1 it wraps to 0 and ch increments.
  - Accept of word NUM_CH*WORDS-1 -> SETTLE.
  - in_valid gaps stall LOAD indefinitely.
- SETTLE: one cycle. Carries the final mem_we. in_ready=0. Then -> START.
  - Guarantees start never coincides with a memory write.
- START: start=1 for exactly START_CYC cycles, then -> WAIT. tpu_ready is ignored here.
- WAIT:
  - start=0. run_cycles increments every cycle.
  - tpu_ready=1 -> DONE, timed_out=0.
  - run_cycles reaching TIMEOUT without tpu_ready -> DONE, timed_out=1.
  - If tpu_ready=1 in the same cycle as the TIMEOUT boundary, ready wins (timed_out=0).
- DONE: done=1 for one cycle, then -> IDLE. timed_out and run_cycles hold until the next accepted go.
- go outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).

Optional Feature:
- Macro: TPU_SEQ_SKIP_LOAD_EN.
- With it: go=1 & skip_load=1 in IDLE -> START directly. Counters clear and weights are reused.
- Without it: skip_load is unused and every go performs a full LOAD.

Decomposition:
- Shared tpu_pkg holds:
  - the state enum
  - default widths (DATA_W, ADDR_W, CNT_W)
- One natural sub-module, tpu_seq_addr_gen: the channel/address counter with wrap and last-word flag.

Test Plan:
- Default params; go, then 4 words 1,1,1,1 back-to-back -> mem_we on 4 cycles with (ch,addr) = (01,0),(01,1),(10,0),(10,1). SETTLE, then start high exactly 2 cycles.
- Same run with in_valid deasserted 3 cycles between words -> identical write sequence, no extra mem_we, start only after the 4th write plus SETTLE.
- tpu_ready raised on WAIT cycle 5 -> done pulse, timed_out=0, run_cycles=5.
- tpu_ready never raised -> done after 20 WAIT cycles, timed_out=1, run_cycles=20. tpu_ready on cycle 20 instead -> timed_out=0.
- rst=0 asserted during START -> start and busy fall asynchronously. After release, go reruns the full LOAD from ch0/addr0.
- With TPU_SEQ_SKIP_LOAD_EN: go with skip_load=1 -> no mem_we, start within 1 cycle. Without the macro -> full LOAD.
